// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for one memory port.
// The requester side drives the strobes and fields; the responder side returns completion and data.
interface mem_port_arbiter_if;
    logic        read;
    logic        write;
    logic [1:0]  wmask;
    logic [15:0] address;
    logic [15:0] wdata;
    logic        resp;
    logic [15:0] rdata;

    modport master (
        output read, write, wmask, address, wdata,
        input  resp, rdata
    );

    modport slave (
        input  read, write, wmask, address, wdata,
        output resp, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto one shared memory port.
// Ties alternate between the ports, and every transaction is followed by one idle cycle.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no transaction; evaluate requests on next edge
// SERVE_A | port A transaction latched and driven to memory
// SERVE_B | port B transaction latched and driven to memory
module mem_port_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    port_a,
    mem_port_arbiter_if.slave    port_b,
    mem_port_arbiter_if.master   mem,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    state_t      state;
    logic        last_grant;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [1:0]  lat_wmask;
    logic [15:0] lat_address;
    logic [15:0] lat_wdata;

    logic        req_a;
    logic        req_b;
    logic        pick_b;
    logic        sel_read;
    logic        sel_write;
    logic [1:0]  sel_wmask;
    logic [15:0] sel_address;
    logic [15:0] sel_wdata;

    assign req_a = port_a.read | port_a.write;
    assign req_b = port_b.read | port_b.write;

    // B wins when it is alone, or on a tie when A was granted last.
    always_comb begin
        pick_b      = req_b & (~req_a | (last_grant == GRANT_A));
        sel_read    = port_a.read;
        sel_write   = port_a.write;
        sel_wmask   = port_a.wmask;
        sel_address = port_a.address;
        sel_wdata   = port_a.wdata;
        if (pick_b) begin
            sel_read    = port_b.read;
            sel_write   = port_b.write;
            sel_wmask   = port_b.wmask;
            sel_address = port_b.address;
            sel_wdata   = port_b.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_A;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            lat_wmask   <= 2'b00;
            lat_address <= 16'h0000;
            lat_wdata   <= 16'h0000;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        state       <= pick_b ? SERVE_B : SERVE_A;
                        last_grant  <= pick_b ? GRANT_B : GRANT_A;
                        // A simultaneous read+write is treated as a write.
                        mem_write_q <= sel_write;
                        mem_read_q  <= sel_read & ~sel_write;
                        lat_wmask   <= sel_wmask;
                        lat_address <= sel_address;
                        lat_wdata   <= sel_wdata;
                        busy        <= 1'b1;
                    end
                end
                SERVE_A, SERVE_B: begin
                    if (mem.resp) begin
                        state       <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign mem.read    = mem_read_q;
    assign mem.write   = mem_write_q;
    assign mem.wmask   = lat_wmask;
    assign mem.address = lat_address;
    assign mem.wdata   = lat_wdata;

    assign port_a.resp  = (state == SERVE_A) & mem.resp;
    assign port_b.resp  = (state == SERVE_B) & mem.resp;
    assign port_a.rdata = mem.rdata;
    assign port_b.rdata = mem.rdata;

endmodule
